dht11_frame_reader: RTL and testbench

Downstream stage of the DHT11 start-sequence block. It arms on the rising edge of that block's `confirm_to_reciver` output, then times the 40 data bits the sensor drives on the shared data line. It shifts the bits into a frame, verifies the checksum, and presents humidity and temperature bytes with a one-cycle valid strobe. It only listens: it never drives the data line.

---
 rtl/dht11_frame_reader.sv | 169 ++++++++++++++++
 tb/tb_dht11_frame_reader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_frame_reader.sv
// DHT11 data-phase receiver: times the 40 data bits after the start handshake,
// verifies the checksum and presents the four payload bytes with a valid strobe.
module dht11_frame_reader #(
    parameter int unsigned CLK_PER_US    = 1,
    parameter int unsigned BIT_THRESHOLD = 40,
    parameter int unsigned TIMEOUT       = 200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       data_in_i,
    output logic [7:0] humidity_int_o,
    output logic [7:0] humidity_dec_o,
    output logic [7:0] temp_int_o,
    output logic [7:0] temp_dec_o,
    output logic       valid_o,
    output logic       checksum_err_o,
    output logic       timeout_err_o,
    output logic       busy_o
);
    localparam int unsigned      CntW       = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0]  TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [CntW:0]    ThreshCnt  = (CntW + 1)'(BIT_THRESHOLD);

    if (CLK_PER_US == 0) begin : g_bad_clk_per_us
        $error("CLK_PER_US must be at least 1");
    end

    typedef enum logic [2:0] {StIdle, StWaitLow, StLow, StHigh, StCheck} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, d_s_q, d_prev_q, start_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      idx_q, idx_d;
    logic [39:0]     shift_q, shift_d;
    logic [7:0]      hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
    logic [7:0]      tmp_int_q, tmp_int_d, tmp_dec_q, tmp_dec_d;
    logic            valid_q, valid_d, cks_err_q, cks_err_d, to_err_q, to_err_d;

    logic       rise, fall, start_edge, timed_out, bit_is_one;
    logic [7:0] checksum;

    assign rise       = d_s_q & ~d_prev_q;
    assign fall       = ~d_s_q & d_prev_q;
    assign start_edge = start_i & ~start_q;
    assign timed_out  = (cnt_q == TimeoutCnt);
    // The rise cycle itself is high but spent in StLow, so the width is cnt_q + 1.
    assign bit_is_one = (({1'b0, cnt_q} + 1'b1) > ThreshCnt);
    assign checksum   = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            sync1_q   <= 1'b0;
            d_s_q     <= 1'b0;
            d_prev_q  <= 1'b0;
            start_q   <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            hum_int_q <= '0;
            hum_dec_q <= '0;
            tmp_int_q <= '0;
            tmp_dec_q <= '0;
            valid_q   <= 1'b0;
            cks_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= data_in_i;
            d_s_q     <= sync1_q;
            d_prev_q  <= d_s_q;
            start_q   <= start_i;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            hum_int_q <= hum_int_d;
            hum_dec_q <= hum_dec_d;
            tmp_int_q <= tmp_int_d;
            tmp_dec_q <= tmp_dec_d;
            valid_q   <= valid_d;
            cks_err_q <= cks_err_d;
            to_err_q  <= to_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        hum_int_d = hum_int_q;
        hum_dec_d = hum_dec_q;
        tmp_int_d = tmp_int_q;
        tmp_dec_d = tmp_dec_q;
        valid_d   = 1'b0;
        cks_err_d = 1'b0;
        to_err_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_edge) begin
                    state_d = StWaitLow;
                    idx_d   = '0;
                    shift_d = '0;
                end
            end
            StWaitLow: begin
                if (timed_out) begin
                    to_err_d = 1'b1;
                    state_d  = StIdle;
                end else if (!d_s_q) begin
                    state_d = StLow;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLow: begin
                if (timed_out) begin
                    to_err_d = 1'b1;
                    state_d  = StIdle;
                end else if (rise) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (timed_out) begin
                    to_err_d = 1'b1;
                    state_d  = StIdle;
                end else if (fall) begin
                    shift_d = {shift_q[38:0], bit_is_one};
                    idx_d   = idx_q + 6'd1;
                    cnt_d   = '0;
                    state_d = (idx_q == 6'd39) ? StCheck : StLow;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (checksum == shift_q[7:0]) begin
                    hum_int_d = shift_q[39:32];
                    hum_dec_d = shift_q[31:24];
                    tmp_int_d = shift_q[23:16];
                    tmp_dec_d = shift_q[15:8];
                    valid_d   = 1'b1;
                end else begin
                    cks_err_d = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign humidity_int_o = hum_int_q;
    assign humidity_dec_o = hum_dec_q;
    assign temp_int_o     = tmp_int_q;
    assign temp_dec_o     = tmp_dec_q;
    assign valid_o        = valid_q;
    assign checksum_err_o = cks_err_q;
    assign timeout_err_o  = to_err_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed/randomized bench for dht11_frame_reader: drives bit-level line waveforms and
// checks strobes and bytes against a width-rule reference model.
module tb_dht11_frame_reader;
    localparam int Thresh = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, data_in;
    logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
    logic       valid, cks_err, to_err, busy;

    dht11_frame_reader #(
        .CLK_PER_US   (1),
        .BIT_THRESHOLD(40),
        .TIMEOUT      (200)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .data_in_i     (data_in),
        .humidity_int_o(hum_int),
        .humidity_dec_o(hum_dec),
        .temp_int_o    (temp_int),
        .temp_dec_o    (temp_dec),
        .valid_o       (valid),
        .checksum_err_o(cks_err),
        .timeout_err_o (to_err),
        .busy_o        (busy)
    );

    int          n_vec, n_err;
    int          n_valid, n_cerr, n_terr, n_conf;
    logic [31:0] v_bytes;
    logic [7:0]  exp_b[4];
    int          hi_w[40];
    int          lo_w[40];

    task automatic tick();
        @(posedge clk);
        #1;
        if (valid) begin
            n_valid++;
            v_bytes = {hum_int, hum_dec, temp_int, temp_dec};
        end
        if (cks_err) n_cerr++;
        if (to_err) n_terr++;
        if ((valid || cks_err || to_err) && busy) n_conf++;
        if (valid && (cks_err || to_err)) n_conf++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid = 0;
        n_cerr  = 0;
        n_terr  = 0;
        n_conf  = 0;
        v_bytes = '0;
    endtask

    // mode 0: random widths, 1: exactly 40/41 high, 2: nominal 50 low, 27/70 high
    task automatic set_widths(input logic [39:0] bits, input int mode);
        for (int i = 0; i < 40; i++) begin
            if (mode == 1) hi_w[i] = bits[39-i] ? 41 : 40;
            else if (mode == 2) hi_w[i] = bits[39-i] ? 70 : 27;
            else hi_w[i] = bits[39-i] ? int'($urandom_range(60, 85)) : int'($urandom_range(18, 35));
            lo_w[i] = (mode == 2) ? 50 : int'($urandom_range(45, 55));
        end
    endtask

    function automatic logic [39:0] make_frame(input logic [31:0] payload, input bit good);
        logic [7:0] s;
        s = payload[31:24] + payload[23:16] + payload[15:8] + payload[7:0];
        if (!good) s = s + 8'($urandom_range(1, 255));
        return {payload, s};
    endfunction

    task automatic send_bits(input int n, input int repulse_at);
        for (int i = 0; i < n; i++) begin
            data_in = 1'b0;
            for (int c = 0; c < lo_w[i]; c++) begin
                if (i == repulse_at && c == 2) start = 1'b0;
                if (i == repulse_at && c == 5) start = 1'b1;
                tick();
            end
            data_in = 1'b1;
            repeat (hi_w[i]) tick();
        end
    endtask

    // Reference: decode each bit from its high width, then apply the checksum rule.
    task automatic expect_frame(input string tag);
        logic [39:0] dec;
        logic [7:0]  b[5];
        bit          good;
        for (int i = 0; i < 40; i++) dec[39-i] = (hi_w[i] > Thresh);
        for (int k = 0; k < 5; k++) b[k] = dec[39-8*k -: 8];
        good = (((int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3])) % 256) == int'(b[4]));
        if (good) for (int k = 0; k < 4; k++) exp_b[k] = b[k];
        check({tag, "_valid_cnt"}, n_valid, good ? 1 : 0);
        check({tag, "_cks_cnt"}, n_cerr, good ? 0 : 1);
        check({tag, "_to_cnt"}, n_terr, 0);
        check({tag, "_strobe_conflict"}, n_conf, 0);
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_bytes"}, {hum_int, hum_dec, temp_int, temp_dec},
              {exp_b[0], exp_b[1], exp_b[2], exp_b[3]});
        if (good) check({tag, "_bytes_at_valid"}, v_bytes, {b[0], b[1], b[2], b[3]});
    endtask

    task automatic full_read(input string tag, input int repulse_at, input int hold_extra);
        clear_counts();
        start   = 1'b1;
        data_in = 1'b1;
        repeat (3) tick();
        check({tag, "_busy_mid"}, busy, 1);
        send_bits(40, repulse_at);
        data_in = 1'b0;
        repeat (50) tick();
        data_in = 1'b1;
        repeat (hold_extra + 10) tick();
        start = 1'b0;
        repeat (3) tick();
        expect_frame(tag);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) exp_b[k] = 8'h00;
        tick();
    endtask

    initial begin
        bit found;
        int waited;
        n_vec = 0;
        n_err = 0;
        clear_counts();
        rst     = 1'b1;
        start   = 1'b0;
        data_in = 1'b1;
        for (int k = 0; k < 4; k++) exp_b[k] = 8'h00;
        repeat (4) tick();
        check("rst_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);
        check("rst_strobes", {valid, cks_err, to_err}, 3'b000);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        set_widths({40'h35_00_18_00_4D}, 2);
        full_read("good", -1, 0);

        pulse_reset();
        set_widths({40'h35_00_18_00_4E}, 2);
        full_read("badsum", -1, 0);

        set_widths(make_frame($urandom, 1'b1), 0);
        full_read("pre_timeout", -1, 0);

        clear_counts();
        start   = 1'b1;
        data_in = 1'b1;
        found   = 1'b0;
        waited  = 0;
        for (int c = 1; c <= 400 && !found; c++) begin
            tick();
            if (to_err) begin
                found  = 1'b1;
                waited = c;
            end
        end
        check("timeout_seen", found, 1);
        check("timeout_window", (waited >= 195 && waited <= 215), 1);
        repeat (5) tick();
        start = 1'b0;
        tick();
        check("timeout_cnt", n_terr, 1);
        check("timeout_no_valid", n_valid, 0);
        check("timeout_conflict", n_conf, 0);
        check("timeout_busy", busy, 0);
        check("timeout_bytes", {hum_int, hum_dec, temp_int, temp_dec},
              {exp_b[0], exp_b[1], exp_b[2], exp_b[3]});

        set_widths(make_frame(32'h5A3C0F81, 1'b1), 1);
        full_read("threshold", -1, 0);

        set_widths(make_frame($urandom, 1'b1), 0);
        clear_counts();
        start = 1'b1;
        repeat (3) tick();
        send_bits(20, -1);
        data_in = 1'b0;
        repeat (10) tick();
        check("midrst_busy_before", busy, 1);
        rst   = 1'b1;
        start = 1'b0;
        tick();
        rst     = 1'b0;
        data_in = 1'b1;
        for (int k = 0; k < 4; k++) exp_b[k] = 8'h00;
        repeat (300) tick();
        check("midrst_busy", busy, 0);
        check("midrst_strobes", n_valid + n_cerr + n_terr, 0);
        check("midrst_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0);

        set_widths(make_frame($urandom, 1'b1), 0);
        full_read("after_rst", -1, 0);

        set_widths(make_frame($urandom, 1'b1), 0);
        full_read("start_held", -1, 300);

        set_widths(make_frame($urandom, 1'b1), 0);
        full_read("repulse", 10, 0);

        for (int f = 0; f < 4; f++) begin
            set_widths(make_frame($urandom, 1'($urandom_range(0, 1))), 0);
            full_read($sformatf("rand%0d", f), -1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
